// File: rtl/sort4_ctrl.sv
// Sequential four-operand signed sort. One shared comparator walks a fixed
// six-step bubble network, doing one compare-and-swap per clock.

module addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {{(W-1){1'b0}}, sub};
    // Two's complement overflow: same-sign inputs that produce a flipped sign.
    assign ovf   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
endmodule

module comparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);
    logic [W-1:0] diff;
    logic         ovf;
    logic         eq;

    addsub #(.W(W)) u_sub (
        .a   (a),
        .b   (b),
        .sub (1'b1),
        .sum (diff),
        .ovf (ovf)
    );

    // N xor V keeps the ordering correct even when a-b overflows.
    assign lt = diff[W-1] ^ ovf;
    assign eq = (diff == '0);
    assign gt = !lt && !eq;
endmodule

module sort4_ctrl #(
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] a3,
    output logic       busy,
    output logic       done,
    output logic [7:0] s0,
    output logic [7:0] s1,
    output logic [7:0] s2,
    output logic [7:0] s3,
    output logic [2:0] swap_count
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      step;
    logic [3:0][7:0] r, r_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [1:0]      lo, hi;
    logic            cmp_gt, cmp_lt, swap;

    // Pair schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
    always_comb begin
        lo = 2'd0;
        case (step)
            3'd1, 3'd4: lo = 2'd1;
            3'd2:       lo = 2'd2;
            default:    lo = 2'd0;
        endcase
    end
    assign hi = lo + 2'd1;

    comparator #(.W(8)) u_cmp (
        .a  (r[lo]),
        .b  (r[hi]),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    assign swap = (state == CMP) && (DESCEND ? cmp_lt : cmp_gt);

    always_comb begin
        r_nxt   = r;
        cnt_nxt = cnt + {2'b00, swap};
        if (swap) begin
            r_nxt[lo] = r[hi];
            r_nxt[hi] = r[lo];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CMP;
            CMP:     if (step == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 3'd0;
            r          <= '0;
            cnt        <= 3'd0;
            s0         <= 8'd0;
            s1         <= 8'd0;
            s2         <= 8'd0;
            s3         <= 8'd0;
            swap_count <= 3'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        r    <= {a3, a2, a1, a0};
                        step <= 3'd0;
                        cnt  <= 3'd0;
                    end
                end
                CMP: begin
                    r    <= r_nxt;
                    cnt  <= cnt_nxt;
                    step <= step + 3'd1;
                    // Publish post-swap values of the last step only, so the
                    // outputs never expose a partially sorted set.
                    if (step == 3'd5) begin
                        s0         <= r_nxt[0];
                        s1         <= r_nxt[1];
                        s2         <= r_nxt[2];
                        s3         <= r_nxt[3];
                        swap_count <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench for sort4_ctrl: ascending and descending instances share
// stimulus; a reference sort plus inversion count supplies expected results.

module tb_sort4_ctrl;
    typedef struct packed {
        logic [3:0][7:0] s;
        logic [2:0]      cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a0 = 8'd0, a1 = 8'd0, a2 = 8'd0, a3 = 8'd0;

    logic       busy_a, done_a, busy_d, done_d;
    logic [7:0] s0_a, s1_a, s2_a, s3_a, s0_d, s1_d, s2_d, s3_d;
    logic [2:0] sc_a, sc_d;

    int n_tests = 0;
    int n_fail  = 0;
    int pushes  = 0;
    int dones_a = 0;
    int dones_d = 0;
    exp_t q_a[$];
    exp_t q_d[$];

    always #5 clk = ~clk;

    sort4_ctrl #(.DESCEND(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .busy(busy_a), .done(done_a),
        .s0(s0_a), .s1(s1_a), .s2(s2_a), .s3(s3_a), .swap_count(sc_a)
    );

    sort4_ctrl #(.DESCEND(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .busy(busy_d), .done(done_d),
        .s0(s0_d), .s1(s1_d), .s2(s2_d), .s3(s3_d), .swap_count(sc_d)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sorted order plus inversion count (the number of swaps any adjacent
    // exchange sort must perform).
    function automatic exp_t model(input logic [3:0][7:0] a, input bit desc);
        int   v[4];
        int   t, n;
        exp_t e;
        n = 0;
        for (int i = 0; i < 4; i++) v[i] = int'($signed(a[i]));
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc ? (v[i] < v[j]) : (v[i] > v[j])) n++;
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
        for (int i = 0; i < 4; i++) e.s[i] = v[i][7:0];
        e.cnt = n[2:0];
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            dones_a++;
            if (q_a.size() == 0) chk("asc_unexpected_done", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("asc_s0", s0_a, e.s[0]);
                chk("asc_s1", s1_a, e.s[1]);
                chk("asc_s2", s2_a, e.s[2]);
                chk("asc_s3", s3_a, e.s[3]);
                chk("asc_swaps", sc_a, e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_d) begin
            dones_d++;
            if (q_d.size() == 0) chk("desc_unexpected_done", 1, 0);
            else begin
                e = q_d.pop_front();
                chk("desc_s0", s0_d, e.s[0]);
                chk("desc_s1", s1_d, e.s[1]);
                chk("desc_s2", s2_d, e.s[2]);
                chk("desc_s3", s3_d, e.s[3]);
                chk("desc_swaps", sc_d, e.cnt);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {30'd0, busy_a, busy_d}, 0);
        chk({tag, "_done"}, {30'd0, done_a, done_d}, 0);
        chk({tag, "_s_asc"}, {s3_a, s2_a, s1_a, s0_a}, 0);
        chk({tag, "_s_desc"}, {s3_d, s2_d, s1_d, s0_d}, 0);
        chk({tag, "_swaps"}, {sc_a, sc_d}, 0);
    endtask

    task automatic drive(input logic [3:0][7:0] a);
        a0 = a[0]; a1 = a[1]; a2 = a[2]; a3 = a[3];
    endtask

    // Full run with latency / busy-width checks; collide re-asserts start
    // with zero operands two clocks after the accept.
    task automatic run(input logic [3:0][7:0] a, input bit collide);
        int cyc, busy_cyc;
        @(negedge clk);
        drive(a);
        start = 1'b1;
        q_a.push_back(model(a, 1'b0));
        q_d.push_back(model(a, 1'b1));
        pushes++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", {31'd0, busy_a && busy_d}, 1);
        chk("accept_done", {31'd0, done_a || done_d}, 0);
        busy_cyc = 1;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (collide && k == 2) begin
                drive('0);
                start = 1'b1;
            end else if (collide && k == 3) begin
                start = 1'b0;
            end
            if (busy_a) busy_cyc++;
            if (done_a) break;
        end
        chk("latency", cyc, 6);
        chk("done_match", {31'd0, done_d}, {31'd0, done_a});
        @(posedge clk); #1;
        chk("busy_width", busy_cyc, 7);
        chk("idle_busy", {30'd0, busy_a, busy_d}, 0);
        chk("idle_done", {30'd0, done_a, done_d}, 0);
    endtask

    task automatic abort_run(input logic [3:0][7:0] a);
        @(negedge clk);
        drive(a);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0][7:0] v;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        run({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);
        run({8'hFF, 8'h00, 8'h80, 8'h7F}, 1'b0);
        run({8'd7, 8'd5, 8'h80, 8'd5}, 1'b0);
        run({8'd9, 8'd9, 8'd9, 8'd9}, 1'b0);
        run({8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
        chk("collide_pulses", dones_a, pushes);
        abort_run({8'd1, 8'd2, 8'd3, 8'd4});
        run({8'd3, 8'd4, 8'd1, 8'd2}, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                case (n % 3)
                    0: v[i] = 8'($urandom);
                    1: v[i] = 8'($urandom_range(0, 3));
                    default: v[i] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
                endcase
            end
            run(v, (n % 7) == 3);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("asc_queue_empty", q_a.size(), 0);
        chk("desc_queue_empty", q_d.size(), 0);
        chk("asc_done_pulses", dones_a, pushes);
        chk("desc_done_pulses", dones_d, pushes);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
